// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty
// thresholds, sticky overflow/underflow flags and optional first-word-fall-through.
module fifo_sync_param #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AF_THRESH = 6,
  parameter int unsigned AE_THRESH = 1,
  parameter int unsigned FWFT      = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       WREN,
  input  logic                       RDEN,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           data_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr_nxt;
  logic [PW-1:0]    rd_ptr_nxt;
  logic             wr_acc;
  logic             rd_acc;

  // Flags decode only the registered count, so inputs never reach them combinationally.
  always_comb begin
    full         = (count == CW'(DEPTH));
    empty        = (count == '0);
    almost_full  = (count >= CW'(AF_THRESH));
    almost_empty = (count <= CW'(AE_THRESH));
    wr_acc       = WREN & ~full;
    rd_acc       = RDEN & ~empty;
  end

  // Explicit wrap compare so non-power-of-two depths work.
  always_comb begin
    wr_ptr_nxt = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
    rd_ptr_nxt = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr_nxt;
      if (rd_acc) rd_ptr <= rd_ptr_nxt;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Setting an error outranks clearing it in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (WREN && full)  overflow <= 1'b1;
      else if (clr_err)  overflow <= 1'b0;
      if (RDEN && empty) underflow <= 1'b1;
      else if (clr_err)  underflow <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = mem[rd_ptr];
    end else begin : g_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          data_out <= '0;
        end else if (rd_acc) begin
          data_out <= mem[rd_ptr];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: a registered-read 8-deep instance and a
// FWFT 5-deep instance, each checked against a queue-based reference model.
module tb_fifo_sync_param;

  localparam int unsigned D0 = 8;
  localparam int unsigned D1 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, wren0, rden0, clr0;
  logic [7:0] din0, dout0;
  logic       full0, empty0, af0, ae0, ovf0, udf0;
  logic [3:0] cnt0;

  logic       rst1, wren1, rden1, clr1;
  logic [7:0] din1, dout1;
  logic       full1, empty1, af1, ae1, ovf1, udf1;
  logic [2:0] cnt1;

  fifo_sync_param #(.WIDTH(8), .DEPTH(D0), .AF_THRESH(6), .AE_THRESH(1), .FWFT(0)) dut0 (
    .clk(clk), .rst(rst0), .WREN(wren0), .RDEN(rden0), .data_in(din0), .clr_err(clr0),
    .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(cnt0), .overflow(ovf0), .underflow(udf0));

  fifo_sync_param #(.WIDTH(8), .DEPTH(D1), .AF_THRESH(4), .AE_THRESH(1), .FWFT(1)) dut1 (
    .clk(clk), .rst(rst1), .WREN(wren1), .RDEN(rden1), .data_in(din1), .clr_err(clr1),
    .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(cnt1), .overflow(ovf1), .underflow(udf1));

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] m_dout0;
  logic       m_ovf0, m_udf0, m_ovf1, m_udf1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model advances on the pre-edge inputs, then the clock edge is taken.
  task automatic tick();
    if (rst0) begin
      q0.delete(); m_ovf0 = 1'b0; m_udf0 = 1'b0; m_dout0 = '0;
    end else begin
      logic w, r;
      w = wren0 && (q0.size() < D0);
      r = rden0 && (q0.size() > 0);
      if (wren0 && q0.size() == D0) m_ovf0 = 1'b1; else if (clr0) m_ovf0 = 1'b0;
      if (rden0 && q0.size() == 0)  m_udf0 = 1'b1; else if (clr0) m_udf0 = 1'b0;
      if (r) m_dout0 = q0.pop_front();
      if (w) q0.push_back(din0);
    end
    if (rst1) begin
      q1.delete(); m_ovf1 = 1'b0; m_udf1 = 1'b0;
    end else begin
      logic w, r;
      w = wren1 && (q1.size() < D1);
      r = rden1 && (q1.size() > 0);
      if (wren1 && q1.size() == D1) m_ovf1 = 1'b1; else if (clr1) m_ovf1 = 1'b0;
      if (rden1 && q1.size() == 0)  m_udf1 = 1'b1; else if (clr1) m_udf1 = 1'b0;
      if (r) void'(q1.pop_front());
      if (w) q1.push_back(din1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check0(input string tag);
    check({tag, ".count"}, 32'(cnt0), 32'(q0.size()));
    check({tag, ".empty"}, 32'(empty0), 32'(q0.size() == 0));
    check({tag, ".full"}, 32'(full0), 32'(q0.size() == D0));
    check({tag, ".afull"}, 32'(af0), 32'(q0.size() >= 6));
    check({tag, ".aempty"}, 32'(ae0), 32'(q0.size() <= 1));
    check({tag, ".ovf"}, 32'(ovf0), 32'(m_ovf0));
    check({tag, ".udf"}, 32'(udf0), 32'(m_udf0));
    check({tag, ".dout"}, 32'(dout0), 32'(m_dout0));
  endtask

  task automatic check1(input string tag);
    check({tag, ".count"}, 32'(cnt1), 32'(q1.size()));
    check({tag, ".empty"}, 32'(empty1), 32'(q1.size() == 0));
    check({tag, ".full"}, 32'(full1), 32'(q1.size() == D1));
    check({tag, ".afull"}, 32'(af1), 32'(q1.size() >= 4));
    check({tag, ".aempty"}, 32'(ae1), 32'(q1.size() <= 1));
    check({tag, ".ovf"}, 32'(ovf1), 32'(m_ovf1));
    check({tag, ".udf"}, 32'(udf1), 32'(m_udf1));
    if (q1.size() > 0) check({tag, ".dout"}, 32'(dout1), 32'(q1[0]));
  endtask

  initial begin
    rst0 = 1'b1; wren0 = 1'b1; rden0 = 1'b0; clr0 = 1'b0; din0 = 8'h55;
    rst1 = 1'b1; wren1 = 1'b1; rden1 = 1'b0; clr1 = 1'b0; din1 = 8'h66;
    m_dout0 = '0; m_ovf0 = 1'b0; m_udf0 = 1'b0; m_ovf1 = 1'b0; m_udf1 = 1'b0;

    // Reset held two cycles with WREN asserted
    tick(); tick();
    check0("reset");
    check("reset.dout_zero", 32'(dout0), 32'h0);
    check1("reset1");
    rst0 = 1'b0; rst1 = 1'b0; wren1 = 1'b0;

    // Fill 1..8, then a 9th write overflows
    for (int i = 1; i <= 9; i++) begin
      din0 = 8'(i); wren0 = 1'b1;
      tick();
      check0("fill");
    end
    check("fill.overflow", 32'(ovf0), 32'h1);
    check("fill.count8", 32'(cnt0), 32'd8);
    wren0 = 1'b0;

    // Drain with registered read, then an extra read underflows
    for (int i = 1; i <= 9; i++) begin
      rden0 = 1'b1;
      tick();
      check0("drain");
      if (i <= 8) check("drain.data", 32'(dout0), 32'(i));
    end
    check("drain.underflow", 32'(udf0), 32'h1);
    check("drain.hold8", 32'(dout0), 32'd8);
    rden0 = 1'b0;

    // clr_err clears both sticky flags
    clr0 = 1'b1;
    tick();
    check0("clr");
    check("clr.ovf0", 32'(ovf0), 32'h0);
    clr0 = 1'b0;

    // Occupancy 4, then 10 cycles of simultaneous read/write across pointer wrap
    for (int i = 0; i < 4; i++) begin
      din0 = 8'(8'h10 + i); wren0 = 1'b1;
      tick();
    end
    check0("sim_pre");
    for (int i = 0; i < 10; i++) begin
      din0 = 8'(8'h20 + i); wren0 = 1'b1; rden0 = 1'b1;
      tick();
      check0("sim");
      check("sim.count4", 32'(cnt0), 32'd4);
    end
    wren0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check0("sim_drain");
    end
    rden0 = 1'b0;

    // Overflow set wins over clr_err; simultaneous access while full
    for (int i = 0; i < 8; i++) begin
      din0 = 8'(8'h40 + i); wren0 = 1'b1;
      tick();
    end
    din0 = 8'hEE; clr0 = 1'b1;
    tick();
    check0("ovf_vs_clr");
    check("ovf_vs_clr.ovf", 32'(ovf0), 32'h1);
    clr0 = 1'b0; rden0 = 1'b1; din0 = 8'hEF;
    tick();
    check0("full_wr_rd");
    rden0 = 1'b0; wren0 = 1'b0;

    // Mid-fill reset discards contents
    rst0 = 1'b1;
    tick();
    check0("midrst");
    check("midrst.empty", 32'(empty0), 32'h1);
    rst0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din0 = 8'(8'h70 + i); wren0 = 1'b1;
      tick();
    end
    wren0 = 1'b0; rst0 = 1'b1;
    tick();
    check0("midfill_rst");
    rst0 = 1'b0;
    // Empty with WREN+RDEN: write accepted, read rejected
    wren0 = 1'b1; rden0 = 1'b1; din0 = 8'h99;
    tick();
    check0("empty_wr_rd");
    wren0 = 1'b0; rden0 = 1'b0;

    // FWFT: word visible immediately after its write edge
    din1 = 8'hA5; wren1 = 1'b1;
    tick();
    wren1 = 1'b0;
    check1("fwft_first");
    check("fwft_first.data", 32'(dout1), 32'hA5);
    tick();
    check("fwft_hold", 32'(dout1), 32'hA5);

    // FWFT wrap: 12 writes interleaved with reads on the 5-deep instance
    for (int i = 0; i < 12; i++) begin
      din1 = 8'(8'hB0 + i); wren1 = 1'b1; rden1 = (i % 3 != 0);
      tick();
      check1("fwft_wrap");
    end
    wren1 = 1'b0; rden1 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check1("fwft_drain");
    end
    rden1 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
